// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: runs one 5-byte SPI mode-0 transaction per poll period and
// publishes quantized 4-bit X/Y plus buttons atomically with a data_valid pulse.
module jstk_spi_reader #(
  parameter int CLK_DIV     = 100,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1500,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  input  logic [1:0] led_cmd,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [3:0] spi_x_out,
  output logic [3:0] spi_y_out,
  output logic [2:0] btn,
  output logic       data_valid,
  output logic       busy
);

  localparam int MAX_A   = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int CNT_MAX = (MAX_A > 2 * CLK_DIV) ? MAX_A : 2 * CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_poll;
  logic [2:0]      r_bit;
  logic [2:0]      r_byte;
  logic [7:0]      r_tx;
  logic [7:0]      r_rx;
  logic [3:0]      r_xq;
  logic [3:0]      r_yq;
  logic            r_first;

  logic            w_sample;
  logic            w_bit_end;
  logic [7:0]      w_rx_next;
  logic            w_unused_rx;

  // MISO is captured in the first high cycle of SCLK; bit ends after the high phase
  always_comb begin
    w_sample  = 1'b0;
    w_bit_end = 1'b0;
    w_rx_next = r_rx;
    if (r_state == S_XFER) begin
      w_sample  = (r_cnt == CW'(CLK_DIV));
      w_bit_end = (r_cnt == CW'(2 * CLK_DIV - 1));
      if (w_sample) begin
        w_rx_next = {r_rx[6:0], miso};
      end else begin
        w_rx_next = r_rx;
      end
    end else begin
      w_rx_next = r_rx;
    end
  end

  assign w_unused_rx = ^w_rx_next[5:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_poll     <= '0;
      r_bit      <= 3'd7;
      r_byte     <= 3'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_xq       <= 4'd8;
      r_yq       <= 4'd8;
      r_first    <= 1'b1;
      ss         <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      spi_x_out  <= 4'd8;
      spi_y_out  <= 4'd8;
      btn        <= 3'd0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // Poll counter keeps running through the transaction so start-to-start is exact
      if (r_poll != PW'(POLL_PERIOD - 1)) begin
        r_poll <= r_poll + PW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (r_first || (r_poll == PW'(POLL_PERIOD - 1))) begin
            r_first <= 1'b0;
            r_poll  <= '0;
            r_tx    <= {6'b100000, led_cmd};
            r_byte  <= 3'd0;
            r_cnt   <= '0;
            ss      <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == CW'(SS_SETUP - 1)) begin
            r_cnt   <= '0;
            r_bit   <= 3'd7;
            sclk    <= 1'b0;
            mosi    <= r_tx[7];
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_XFER: begin
          r_rx <= w_rx_next;
          if (w_bit_end) begin
            r_cnt <= '0;
            sclk  <= 1'b0;
            if (r_bit == 3'd0) begin
              case (r_byte)
                3'd0:    r_xq[1:0] <= w_rx_next[7:6];
                3'd1:    r_xq[3:2] <= w_rx_next[1:0];
                3'd2:    r_yq[1:0] <= w_rx_next[7:6];
                3'd3:    r_yq[3:2] <= w_rx_next[1:0];
                default: r_xq      <= r_xq;
              endcase
              if (r_byte == 3'd4) begin
                ss         <= 1'b1;
                data_valid <= 1'b1;
                spi_x_out  <= r_xq;
                spi_y_out  <= r_yq;
                btn        <= w_rx_next[2:0];
                r_state    <= S_DONE;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_bit <= r_bit - 3'd1;
              r_tx  <= {r_tx[6:0], 1'b0};
              mosi  <= r_tx[6];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            sclk  <= (r_cnt >= CW'(CLK_DIV - 1));
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(BYTE_GAP - 1)) begin
            r_cnt   <= '0;
            r_byte  <= r_byte + 3'd1;
            r_bit   <= 3'd7;
            r_tx    <= 8'h00;
            mosi    <= 1'b0;
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          ss      <= 1'b1;
          sclk    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Self-checking bench for jstk_spi_reader: PmodJSTK slave model, table of
// fixed and random samples, and hand sequences for LED latching and reset abort.
module tb_jstk_spi_reader;

  localparam int CLK_DIV     = 2;
  localparam int SS_SETUP    = 4;
  localparam int BYTE_GAP    = 3;
  localparam int POLL_PERIOD = 200;
  localparam int XFER_LEN    = SS_SETUP + 80 * CLK_DIV + 4 * BYTE_GAP;
  localparam int NVEC        = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       miso = 1'b0;
  logic [1:0] led_cmd;
  logic       ss, sclk, mosi, data_valid, busy;
  logic [3:0] spi_x_out, spi_y_out;
  logic [2:0] btn;

  jstk_spi_reader #(
    .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .miso(miso), .led_cmd(led_cmd),
    .ss(ss), .sclk(sclk), .mosi(mosi),
    .spi_x_out(spi_x_out), .spi_y_out(spi_y_out), .btn(btn),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
    logic [1:0] led;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [2:0] eb;
  } vec_t;

  vec_t tbl [NVEC];

  int vectors = 0;
  int miscompares = 0;

  // Joystick slave model state
  logic [9:0]  s_x = 10'd0, s_y = 10'd0;
  logic [2:0]  s_b = 3'd0;
  logic [39:0] sh = 40'd0, mosi_cap = 40'd0;
  int rise_cnt = 0, low_cnt = 0, proto_err = 0, busy_err = 0, dv_total = 0;
  int cyc = 0, last_fall = 0, fall_gap = 0;
  logic p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: presents the 40 response bits MSB first, shifting on SCLK falls; captures MOSI on rises
  always @(negedge clk) begin
    if (p_ss && !ss) begin
      sh = {s_x[7:0], 6'($urandom), s_x[9:8], s_y[7:0], 6'($urandom), s_y[9:8], 5'($urandom), s_b};
      miso = sh[39];
      rise_cnt = 0;
      low_cnt = 0;
      mosi_cap = 40'd0;
      fall_gap = cyc - last_fall;
      last_fall = cyc;
    end
    if (!ss) low_cnt++;
    if (!p_sclk && sclk) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[38:0], mosi};
      if (mosi !== p_mosi) proto_err++;
    end
    if (p_sclk && !sclk) begin
      sh = {sh[38:0], 1'b0};
      miso = sh[39];
    end
    if (ss && sclk) proto_err++;
    if (busy !== (!ss || data_valid)) busy_err++;
    if (data_valid === 1'b1) dv_total++;
    p_ss = ss;
    p_sclk = sclk;
    p_mosi = mosi;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_dv(input logic [3:0] hx, input logic [3:0] hy, input logic [2:0] hb,
                         output int bad);
    int n;
    n = 0;
    bad = 0;
    @(negedge clk);
    while (data_valid !== 1'b1 && n < 1000) begin
      if (spi_x_out !== hx || spi_y_out !== hy || btn !== hb) bad++;
      n++;
      @(negedge clk);
    end
    check("dv_seen", 64'(data_valid), 64'd1);
  endtask

  task automatic wait_ss_low();
    int n;
    n = 0;
    while (ss !== 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("ss_fall_seen", 64'(ss), 64'd0);
  endtask

  task automatic load_random();
    s_x = 10'($urandom);
    s_y = 10'($urandom);
    s_b = 3'($urandom);
  endtask

  task automatic check_sample(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                              input logic [2:0] eb);
    check({tag, "_x"}, 64'(spi_x_out), 64'(ex));
    check({tag, "_y"}, 64'(spi_y_out), 64'(ey));
    check({tag, "_btn"}, 64'(btn), 64'(eb));
    check({tag, "_ss_high"}, 64'(ss), 64'd1);
    check({tag, "_rises"}, 64'(rise_cnt), 64'd40);
    check({tag, "_ss_low_len"}, 64'(low_cnt), 64'(XFER_LEN));
  endtask

  initial begin
    logic [3:0] hx, hy, ex, ey;
    logic [2:0] hb, eb;
    int bad, exp_dv;

    tbl[0] = '{10'h3FF, 10'h000, 3'b101, 2'b00, 4'd15, 4'd0, 3'd5};
    tbl[1] = '{10'h200, 10'h1C0, 3'b010, 2'b01, 4'd8, 4'd7, 3'd2};
    tbl[2] = '{10'h03F, 10'h3C0, 3'b111, 2'b10, 4'd0, 4'd15, 3'd7};
    for (int i = 3; i < NVEC; i++) begin
      tbl[i].x   = 10'($urandom);
      tbl[i].y   = 10'($urandom);
      tbl[i].b   = 3'($urandom);
      tbl[i].led = 2'($urandom);
      tbl[i].ex  = 4'(tbl[i].x / 10'd64);
      tbl[i].ey  = 4'(tbl[i].y / 10'd64);
      tbl[i].eb  = tbl[i].b;
    end

    rst = 1'b1;
    led_cmd = tbl[0].led;
    s_x = tbl[0].x; s_y = tbl[0].y; s_b = tbl[0].b;
    repeat (3) @(negedge clk);
    check("rst_ss", 64'(ss), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_x", 64'(spi_x_out), 64'd8);
    check("rst_y", 64'(spi_y_out), 64'd8);
    check("rst_btn", 64'(btn), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    proto_err = 0;
    busy_err = 0;
    dv_total = 0;
    exp_dv = 0;

    rst = 1'b0;
    @(negedge clk);
    check("start_after_release", 64'(ss), 64'd0);
    hx = 4'd8; hy = 4'd8; hb = 3'd0;

    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) begin
        s_x = tbl[i].x; s_y = tbl[i].y; s_b = tbl[i].b;
        led_cmd = tbl[i].led;
      end
      wait_dv(hx, hy, hb, bad);
      exp_dv++;
      check_sample($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eb);
      check($sformatf("vec%0d_mosi", i), 64'(mosi_cap), 64'({6'b100000, tbl[i].led, 32'h0}));
      check($sformatf("vec%0d_hold", i), 64'(bad), 64'd0);
      if (i > 0) check($sformatf("vec%0d_period", i), 64'(fall_gap), 64'(POLL_PERIOD));
      hx = tbl[i].ex; hy = tbl[i].ey; hb = tbl[i].eb;
    end

    // LED bits latched at transaction start; a mid-byte change only affects the next one
    load_random();
    led_cmd = 2'b11;
    wait_ss_low();
    repeat (15) @(negedge clk);
    led_cmd = 2'b00;
    ex = 4'(s_x / 10'd64); ey = 4'(s_y / 10'd64); eb = s_b;
    wait_dv(hx, hy, hb, bad);
    exp_dv++;
    check_sample("led", ex, ey, eb);
    check("led_mosi_83", 64'(mosi_cap), 64'h83_0000_0000);
    hx = ex; hy = ey; hb = eb;
    load_random();
    ex = 4'(s_x / 10'd64); ey = 4'(s_y / 10'd64); eb = s_b;
    wait_dv(hx, hy, hb, bad);
    exp_dv++;
    check_sample("led_next", ex, ey, eb);
    check("led_mosi_80", 64'(mosi_cap), 64'h80_0000_0000);
    check("led_next_period", 64'(fall_gap), 64'(POLL_PERIOD));
    check("led_next_hold", 64'(bad), 64'd0);

    // Reset in the middle of byte 2 discards the partial sample
    load_random();
    wait_ss_low();
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss", 64'(ss), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd0);
    check("abort_outs", 64'({spi_x_out, spi_y_out, btn}), 64'({4'd8, 4'd8, 3'd0}));
    check("abort_dv", 64'(data_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load_random();
    ex = 4'(s_x / 10'd64); ey = 4'(s_y / 10'd64); eb = s_b;
    @(negedge clk);
    check("restart_ss", 64'(ss), 64'd0);
    wait_dv(4'd8, 4'd8, 3'd0, bad);
    exp_dv++;
    check_sample("restart", ex, ey, eb);
    check("restart_hold", 64'(bad), 64'd0);

    repeat (5) @(negedge clk);
    check("protocol_errors", 64'(proto_err), 64'd0);
    check("busy_errors", 64'(busy_err), 64'd0);
    check("dv_pulses", 64'(dv_total), 64'(exp_dv));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
